// File: rtl/legacy_bus_pkg.sv
// legacy_bus_pkg: shared state type, default timing and latched-command layout
package legacy_bus_pkg;
  localparam int SETUP = 1;
  localparam int PULSE = 2;
  localparam int HOLD = 1;
  localparam int TIMEOUT = 16;
  localparam int CMD_ADDR_W = 32;
  localparam int CMD_DATA_W = 32;
  typedef enum logic [2:0] {IDLE, AXI_WR, LEG_SETUP, LEG_PULSE, LEG_HOLD} state_e;
  typedef struct packed {
    logic legacy;
    logic rd;
    logic [CMD_ADDR_W-1:0] addr;
    logic [CMD_DATA_W-1:0] data;
  } cmd_t;
  function automatic int max2(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/bus_phase_timer.sv
// bus_phase_timer: loadable saturating down-counter, done while the count sits at zero
module bus_phase_timer #(
  parameter int W = 5
) (
  input  logic         clk_sys,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);
  logic [W-1:0] count;
  // load wins; otherwise count down and park at zero
  always_ff @(posedge clk_sys or negedge rst_n)
    if (!rst_n) count <= '0;
    else if (load) count <= load_val;
    else if (count != '0) count <= count - 1'b1;
  assign done = count == '0;
endmodule

// File: rtl/axi_legacy_wr_initiator.sv
// axi_legacy_wr_initiator: issues each command as an AXI write or a legacy CS_N/strobe cycle
module axi_legacy_wr_initiator
  import legacy_bus_pkg::*;
#(
  parameter int ADDR_W = CMD_ADDR_W,
  parameter int DATA_W = CMD_DATA_W,
  parameter int SETUP_CYC = SETUP,
  parameter int PULSE_CYC = PULSE,
  parameter int HOLD_CYC = HOLD,
  parameter int TIMEOUT_CYC = TIMEOUT
) (
  input  logic              clk_sys,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_legacy,
  input  logic              cmd_rd,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              AWVALID,
  output logic [ADDR_W-1:0] AWADDR,
  input  logic              AWREADY,
  output logic              WVALID,
  output logic [DATA_W-1:0] WDATA,
  input  logic              WREADY,
  output logic              CS_N,
  output logic              WR_N,
  output logic              RD_N,
  output logic [ADDR_W-1:0] leg_addr,
  output logic [DATA_W-1:0] leg_wdata,
  input  logic [DATA_W-1:0] leg_rdata,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              transaction_complete,
  output logic              error_detected
);
  localparam int TW = $clog2(max2(max2(SETUP_CYC, PULSE_CYC), max2(HOLD_CYC, TIMEOUT_CYC)) + 1);
  state_e state, state_nxt;
  cmd_t cmd_q, cmd_nxt;
  logic aw_nxt, w_nxt, cs_nxt, wr_nxt, rd_nxt, cpl_nxt, err_nxt, t_load, t_done;
  logic [DATA_W-1:0] rsp_nxt;
  logic [TW-1:0] t_val;
  bus_phase_timer #(.W(TW)) u_timer (
    .clk_sys(clk_sys),
    .rst_n(rst_n),
    .load(t_load),
    .load_val(t_val),
    .done(t_done)
  );
  assign AWADDR = ADDR_W'(cmd_q.addr);
  assign leg_addr = ADDR_W'(cmd_q.addr);
  assign WDATA = DATA_W'(cmd_q.data);
  assign leg_wdata = DATA_W'(cmd_q.data);
  // state, latched command and every output bit live in this register bank
  always_ff @(posedge clk_sys or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cmd_q <= '0;
      cmd_ready <= 1'b1;
      AWVALID <= 1'b0;
      WVALID <= 1'b0;
      CS_N <= 1'b1;
      WR_N <= 1'b1;
      RD_N <= 1'b1;
      rsp_rdata <= '0;
      transaction_complete <= 1'b0;
      error_detected <= 1'b0;
    end else begin
      state <= state_nxt;
      cmd_q <= cmd_nxt;
      cmd_ready <= state_nxt == IDLE;
      AWVALID <= aw_nxt;
      WVALID <= w_nxt;
      CS_N <= cs_nxt;
      WR_N <= wr_nxt;
      RD_N <= rd_nxt;
      rsp_rdata <= rsp_nxt;
      transaction_complete <= cpl_nxt;
      error_detected <= err_nxt;
    end
  // next state and next output values; the shared timer is reloaded on every phase entry
  always_comb begin
    state_nxt = state;
    cmd_nxt = cmd_q;
    aw_nxt = AWVALID;
    w_nxt = WVALID;
    cs_nxt = 1'b1;
    wr_nxt = 1'b1;
    rd_nxt = 1'b1;
    rsp_nxt = rsp_rdata;
    cpl_nxt = 1'b0;
    err_nxt = 1'b0;
    t_load = 1'b0;
    t_val = '0;
    case (state)
      IDLE: if (cmd_valid && cmd_ready) begin
        cmd_nxt = '{legacy: cmd_legacy, rd: cmd_rd, addr: CMD_ADDR_W'(cmd_addr), data: CMD_DATA_W'(cmd_data)};
        if (cmd_legacy) begin
          state_nxt = LEG_SETUP;
          cs_nxt = 1'b0;
          t_load = 1'b1;
          t_val = TW'(SETUP_CYC - 1);
        end else if (cmd_rd) begin
          err_nxt = 1'b1;
        end else begin
          state_nxt = AXI_WR;
          aw_nxt = 1'b1;
          w_nxt = 1'b1;
          t_load = 1'b1;
          t_val = TW'(TIMEOUT_CYC - 1);
        end
      end
      AXI_WR: begin
        aw_nxt = AWVALID & ~AWREADY;
        w_nxt = WVALID & ~WREADY;
        if (!aw_nxt && !w_nxt) begin
          state_nxt = IDLE;
          cpl_nxt = 1'b1;
        end else if (t_done) begin
          state_nxt = IDLE;
          aw_nxt = 1'b0;
          w_nxt = 1'b0;
          err_nxt = 1'b1;
        end
      end
      LEG_SETUP: begin
        cs_nxt = 1'b0;
        if (t_done) begin
          state_nxt = LEG_PULSE;
          wr_nxt = ~(cmd_q.legacy & ~cmd_q.rd);
          rd_nxt = ~(cmd_q.legacy & cmd_q.rd);
          t_load = 1'b1;
          t_val = TW'(PULSE_CYC - 1);
        end
      end
      LEG_PULSE: begin
        cs_nxt = 1'b0;
        wr_nxt = WR_N;
        rd_nxt = RD_N;
        if (t_done) begin
          state_nxt = LEG_HOLD;
          wr_nxt = 1'b1;
          rd_nxt = 1'b1;
          rsp_nxt = cmd_q.rd ? leg_rdata : rsp_rdata;
          t_load = 1'b1;
          t_val = TW'(HOLD_CYC - 1);
        end
      end
      LEG_HOLD: begin
        cs_nxt = t_done;
        if (t_done) begin
          state_nxt = IDLE;
          cpl_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: doc/axi_legacy_wr_initiator.md
# axi_legacy_wr_initiator

Command-driven bus initiator that generates the transmitter side of the system's write interfaces. Each accepted command is issued either as an AXI-style write on independent address and data channels, or as a chip-select/strobe cycle on the active-low legacy bus. Completion and failure are reported as single-cycle pulses. It sits between a local command source (sequencer or CPU shim) and peripherals that expose AXI write channels or legacy CS_N/WR_N/RD_N pins.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- SETUP_CYC, 1, legacy cycles with CS_N low before strobe; ≥1
- PULSE_CYC, 2, legacy cycles with strobe low; ≥1
- HOLD_CYC, 1, legacy cycles with CS_N low after strobe; ≥1
- TIMEOUT_CYC, 16, AXI cycles allowed before abort; ≥2

Ports:
- clk_sys  in  1  single clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when both cmd_valid and cmd_ready are high at an edge
- cmd_legacy  in  1  1 = legacy bus, 0 = AXI write
- cmd_rd  in  1  legacy read; illegal with cmd_legacy=0
- cmd_addr  in  ADDR_W  address
- cmd_data  in  DATA_W  write data
- AWVALID / AWADDR  out  1 / ADDR_W  AXI write-address channel
- AWREADY  in  1  address accepted
- WVALID / WDATA  out  1 / DATA_W  AXI write-data channel
- WREADY  in  1  data accepted
- CS_N, WR_N, RD_N  out  1 each  legacy strobes, active-low
- leg_addr / leg_wdata  out  ADDR_W / DATA_W  legacy address/data, stable while CS_N low
- leg_rdata  in  DATA_W  legacy read data
- rsp_rdata  out  DATA_W  captured read data, valid with transaction_complete
- transaction_complete  out  1  one-cycle success pulse
- error_detected  out  1  one-cycle failure pulse

## Operation
- All outputs registered. Reset values: cmd_ready=1; AWVALID, WVALID, transaction_complete, error_detected = 0; CS_N, WR_N, RD_N = 1; all buses = 0.
- States: IDLE, AXI_WR, LEG_SETUP, LEG_PULSE, LEG_HOLD.
- cmd_ready is high only in IDLE. Address and data are latched at acceptance.
- Accept with cmd_legacy=0, cmd_rd=1: error_detected pulses in the next cycle, no bus activity, state stays IDLE.
- AXI_WR:
  - AWVALID and WVALID both rise in the cycle after acceptance.
  - Each channel holds its VALID and payload until it sees READY at an edge, then drops VALID on the following cycle. The channels are independent; either may finish first.
  - When both channels are done, transaction_complete pulses and the block returns to IDLE.
- AXI timeout:
  - A cycle counter starts at acceptance.
  - If TIMEOUT_CYC cycles elapse with either channel still outstanding, both VALIDs drop, error_detected pulses, and the block returns to IDLE.
  - This is a documented abort for a hung responder.
- Legacy cycle:
  - LEG_SETUP: CS_N=0 for SETUP_CYC cycles.
  - LEG_PULSE: CS_N=0, and WR_N=0 (write) or RD_N=0 (read), for PULSE_CYC cycles. On a read, leg_rdata is captured into rsp_rdata at the edge that ends the last pulse cycle.
  - LEG_HOLD: CS_N=0, strobes high, for HOLD_CYC cycles.
  - Then CS_N=1, transaction_complete pulses, and the block returns to IDLE.
  - WR_N and RD_N are never low together. A strobe is never low while CS_N is high.
- Reset asserted mid-operation: all outputs go to reset values immediately. Any in-flight command is dropped silently, with no completion or error pulse.
- Counters are sized as $clog2(max parameter + 1) and saturate; they never wrap.

## Timing
- AXI path, AWREADY=WREADY=1:
  - Cycle 0: accept.
  - Cycle 1: VALIDs high.
  - Cycle 2: VALIDs low, transaction_complete=1, cmd_ready=1.
  - Minimum command period is 2 cycles.
- AXI, AWREADY at cycle 1 and WREADY at cycle 4: AWVALID is high for cycle 1 only, WVALID for cycles 1–4, completion pulses in cycle 5.
- Legacy path:
  - CS_N is low for exactly SETUP_CYC+PULSE_CYC+HOLD_CYC cycles, starting the cycle after acceptance.
  - The completion pulse comes in the first cycle with CS_N high.
  - With defaults, CS_N is low in cycles 1–4 and completion is in cycle 5.
- A back-to-back legacy command can be accepted in the completion cycle. CS_N then goes high for that one cycle, so there is at least 1 idle cycle between chip selects.
- The timeout error pulse occurs in cycle TIMEOUT_CYC+1 after acceptance.
- transaction_complete and error_detected are never high in the same cycle.

## Structure
- Package legacy_bus_pkg holds:
  - the state enum type state_e;
  - default timing localparams SETUP/PULSE/HOLD/TIMEOUT;
  - a cmd_t struct (legacy, rd, addr, data) for the latched command.
- Sub-module bus_phase_timer: a loadable saturating down-counter with a done flag. One instance is shared by the legacy phases and the AXI timeout.
- The top level contains the FSM, the command register and the output registers.

## Test plan
- AXI write 0x1000/0xDEADBEEF with READY tied high → VALIDs high only in cycle 1, AWADDR=0x1000, WDATA=0xDEADBEEF, complete in cycle 2.
- AXI with WREADY at cycle 4 and AWREADY at cycle 1 → WVALID stable with WDATA held for cycles 1–4, complete in cycle 5, no error.
- AXI with READY held low → error_detected in cycle 17, VALIDs low from cycle 17, cmd_ready=1, no complete pulse.
- Legacy read with leg_rdata=0x5A5A5A5A during the pulse → CS_N low cycles 1–4, RD_N low cycles 2–3, WR_N stays 1, rsp_rdata=0x5A5A5A5A, complete in cycle 5.
- Illegal command (cmd_legacy=0, cmd_rd=1) → error pulse in cycle 1, no AXI/legacy activity. Then rst_n asserted during LEG_PULSE → CS_N/WR_N=1 immediately, cmd_ready=1, no pulses.
